// File: rtl/imu_pkg.sv
// Shared types and command words for the IMU read sequencer.
package imu_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StW0,
    StW1,
    StW2,
    StIdle,
    StRdl,
    StRdh
  } imu_state_t;

  localparam logic [15:0] RD_YAWL  = 16'hA600;
  localparam logic [15:0] RD_YAWH  = 16'hA700;
  localparam logic [15:0] CFG0_DEF = 16'h0D02;
  localparam logic [15:0] CFG1_DEF = 16'h1160;
  localparam logic [15:0] CFG2_DEF = 16'h1440;

endpackage

// File: rtl/imu_int_sync.sv
// Two-flop synchronizer for the asynchronous IMU data-ready line.
module imu_int_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/imu_rd_seq.sv
// SPI transaction sequencer: power-up wait, three config writes, then yaw-rate reads on INT.
// Optional build macro YAW_AVG_EN: yaw_rt is the mean of the last four raw samples.
module imu_rd_seq
  import imu_pkg::*;
#(
  parameter int unsigned PWRUP_CYC = 65536,
  parameter logic [15:0] CFG0      = CFG0_DEF,
  parameter logic [15:0] CFG1      = CFG1_DEF,
  parameter logic [15:0] CFG2      = CFG2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cfg_done
);

  localparam int unsigned CntW = $clog2(PWRUP_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(PWRUP_CYC - 1);

  imu_state_t      state_q, state_d;
  logic            issue_q, issue_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     wt_data_q, wt_data_d;
  logic [7:0]      yawl_q, yawl_d;
  logic [15:0]     yaw_q, yaw_d;
  logic            vld_q, vld_d;
  logic            cfg_done_q, cfg_done_d;
  logic            int_sync;
  logic [15:0]     raw;

  imu_int_sync u_int_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(INT),
    .sync_o (int_sync)
  );

  assign raw = {rd_data[7:0], yawl_q};

`ifdef YAW_AVG_EN
  logic [3:0][15:0]    hist_q, hist_d;
  logic signed [17:0]  sum_q, sum_d;
`endif

  always_comb begin
    state_d    = state_q;
    issue_d    = 1'b0;
    cnt_d      = cnt_q;
    wt_data_d  = wt_data_q;
    yawl_d     = yawl_q;
    yaw_d      = yaw_q;
    vld_d      = 1'b0;
    cfg_done_d = cfg_done_q;
`ifdef YAW_AVG_EN
    hist_d     = hist_q;
    sum_d      = sum_q;
`endif
    // issue_q is only ever set for the single ISSUE cycle; done is looked at only when it is clear.
    unique case (state_q)
      StPwrup: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d   = StW0;
          issue_d   = 1'b1;
          wt_data_d = CFG0;
        end
      end
      StW0: begin
        if (!issue_q && done) begin
          state_d   = StW1;
          issue_d   = 1'b1;
          wt_data_d = CFG1;
        end
      end
      StW1: begin
        if (!issue_q && done) begin
          state_d   = StW2;
          issue_d   = 1'b1;
          wt_data_d = CFG2;
        end
      end
      StW2: begin
        if (!issue_q && done) begin
          state_d    = StIdle;
          cfg_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (int_sync) begin
          state_d   = StRdl;
          issue_d   = 1'b1;
          wt_data_d = RD_YAWL;
        end
      end
      StRdl: begin
        if (!issue_q && done) begin
          yawl_d    = rd_data[7:0];
          state_d   = StRdh;
          issue_d   = 1'b1;
          wt_data_d = RD_YAWH;
        end
      end
      StRdh: begin
        if (!issue_q && done) begin
          state_d = StIdle;
          vld_d   = 1'b1;
`ifdef YAW_AVG_EN
          // Running sum over a 4-deep window; dropping bits [1:0] floors toward -inf.
          sum_d  = sum_q + {{2{raw[15]}}, raw} - {{2{hist_q[3][15]}}, hist_q[3]};
          hist_d = {hist_q[2:0], raw};
          yaw_d  = sum_d[17:2];
`else
          yaw_d  = raw;
`endif
        end
      end
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StPwrup;
      issue_q    <= 1'b0;
      cnt_q      <= '0;
      wt_data_q  <= 16'h0000;
      yawl_q     <= 8'h00;
      yaw_q      <= 16'h0000;
      vld_q      <= 1'b0;
      cfg_done_q <= 1'b0;
`ifdef YAW_AVG_EN
      hist_q     <= '0;
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      cnt_q      <= cnt_d;
      wt_data_q  <= wt_data_d;
      yawl_q     <= yawl_d;
      yaw_q      <= yaw_d;
      vld_q      <= vld_d;
      cfg_done_q <= cfg_done_d;
`ifdef YAW_AVG_EN
      hist_q     <= hist_d;
      sum_q      <= sum_d;
`endif
    end
  end

  assign wrt      = issue_q;
  assign wt_data  = wt_data_q;
  assign yaw_rt   = yaw_q;
  assign vld      = vld_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_imu_rd_seq.sv
// Scoreboard bench for imu_rd_seq with an SPI monarch stub and a yaw-rate reference model.
module tb_imu_rd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        cfg_done;

  imu_rd_seq #(
    .PWRUP_CYC(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .wt_data (wt_data),
    .yaw_rt  (yaw_rt),
    .vld     (vld),
    .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [15:0] cmdq[$];   // expected SPI commands in order
  logic [7:0]  rdq[$];    // bytes the stub returns for reads
  logic [15:0] yawq[$];   // expected yaw_rt at each vld
  int          hist[$];   // model history, newest first
  int          a600_cnt = 0;
  int          a700_cnt = 0;
  int          vld_cnt  = 0;
  bit          long_dly = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_yaw(input logic [15:0] s);
`ifdef YAW_AVG_EN
    int sum = 0;
    hist.push_front(int'($signed(s)));
    if (hist.size() > 4) void'(hist.pop_back());
    foreach (hist[i]) sum += hist[i];
    return 16'(sum >>> 2);
`else
    return s;
`endif
  endfunction

  // SPI monarch stub: clears done after wrt, raises it a few cycles later.
  bit          busy = 1'b0;
  int          dly  = 0;
  logic [7:0]  pend = 8'h00;
  logic [15:0] last_cmd = 16'h0000;

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      done = 1'b0;
    end else if (wrt) begin
      check("wrt_while_busy", {31'd0, busy}, 32'd0);
      if (cmdq.size() == 0) check("unexpected_cmd", {16'd0, wt_data}, 32'hFFFF_FFFF);
      else check("cmd", {16'd0, wt_data}, {16'd0, cmdq.pop_front()});
      if (wt_data == 16'hA600) a600_cnt++;
      if (wt_data == 16'hA700) a700_cnt++;
      pend = (wt_data[15] && rdq.size() > 0) ? rdq.pop_front() : 8'($urandom);
      last_cmd = wt_data;
      busy = 1'b1;
      done = 1'b0;
      dly  = long_dly ? 20 : int'($urandom_range(2, 6));
    end else if (busy) begin
      dly--;
      if (dly == 0) begin
        check("wt_data_hold", {16'd0, wt_data}, {16'd0, last_cmd});
        rd_data = {8'($urandom), pend};
        done = 1'b1;
        busy = 1'b0;
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (!rst && vld) begin
      vld_cnt++;
      if (yawq.size() == 0) check("unexpected_vld", {16'd0, yaw_rt}, 32'hFFFF_FFFF);
      else check("yaw_rt", {16'd0, yaw_rt}, {16'd0, yawq.pop_front()});
    end
  end

  task automatic push_cfg();
    cmdq.push_back(16'h0D02);
    cmdq.push_back(16'h1160);
    cmdq.push_back(16'h1440);
  endtask

  // Called right after rst is released on a negedge; INT is pulsed during power-up and must be ignored.
  task automatic bring_up();
    int  cyc  = 0;
    bit  seen = 1'b0;
    INT = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 5) INT = 1'b0;
      if (wrt) seen = 1'b1;
    end
    check("first_wrt_cycle", cyc, 16);
    check("cfg_done_early", {31'd0, cfg_done}, 32'd0);
    for (int i = 0; i < 200 && !cfg_done; i++) @(negedge clk);
    check("cfg_done", {31'd0, cfg_done}, 32'd1);
    repeat (8) @(negedge clk);
    check("cfg_cmds_left", cmdq.size(), 0);
  endtask

  task automatic wait_reads(input int tgt);
    for (int i = 0; i < 300 && a600_cnt < tgt; i++) @(negedge clk);
    INT = 1'b0;
    check("read_started", a600_cnt, tgt);
  endtask

  task automatic wait_vld(input int tgt);
    for (int i = 0; i < 300 && vld_cnt < tgt; i++) @(negedge clk);
    check("vld_seen", vld_cnt, tgt);
  endtask

  task automatic queue_read(input logic [15:0] s);
    rdq.push_back(s[7:0]);
    rdq.push_back(s[15:8]);
    cmdq.push_back(16'hA600);
    cmdq.push_back(16'hA700);
    yawq.push_back(model_yaw(s));
  endtask

  task automatic do_read(input logic [15:0] s);
    int r = a600_cnt + 1;
    int v = vld_cnt + 1;
    queue_read(s);
    INT = 1'b1;
    wait_reads(r);
    wait_vld(v);
    repeat (int'($urandom_range(0, 4))) @(negedge clk);
  endtask

  task automatic do_pair(input logic [15:0] s0, input logic [15:0] s1);
    int r = a600_cnt + 2;
    int v = vld_cnt + 2;
    queue_read(s0);
    queue_read(s1);
    INT = 1'b1;
    wait_reads(r);
    wait_vld(v);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_wt_data", {16'd0, wt_data}, 32'd0);
    check("rst_yaw_rt", {16'd0, yaw_rt}, 32'd0);
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);

    push_cfg();
    rst = 1'b0;
    bring_up();

    do_read(16'h1234);
    do_read(16'hFFF0);
    do_read(16'd100);
    do_read(16'd200);
    do_read(16'd300);
    do_read(16'd400);
    do_pair(16'h8001, 16'h7FFF);
    for (int k = 0; k < 10; k++) do_read(16'($urandom));

    // Abort in the middle of the high-byte read.
    long_dly = 1'b1;
    queue_read(16'h5A5A);
    INT = 1'b1;
    for (int i = 0; i < 300 && a700_cnt < a600_cnt; i++) @(negedge clk);
    INT = 1'b0;
    check("rdh_reached", a700_cnt, a600_cnt);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_wrt", {31'd0, wrt}, 32'd0);
    check("abort_wt_data", {16'd0, wt_data}, 32'd0);
    check("abort_yaw_rt", {16'd0, yaw_rt}, 32'd0);
    check("abort_vld", {31'd0, vld}, 32'd0);
    check("abort_cfg_done", {31'd0, cfg_done}, 32'd0);
    @(negedge clk);
    rdq.delete();
    cmdq.delete();
    yawq.delete();
    hist.delete();
    long_dly = 1'b0;
    push_cfg();
    @(negedge clk);
    rst = 1'b0;
    bring_up();
    do_read(16'hBEEF);
    do_read(16'h0001);

    repeat (20) @(negedge clk);
    check("cmds_left", cmdq.size(), 0);
    check("yaws_left", yawq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", checks);
    $fatal(1);
  end

endmodule
